// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver capture and register-side pop signals of the UART receive FIFO
interface uart_rx_fifo_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              rx_done;
    logic [WIDTH-1:0]  rx_data;
    logic              rx_error;
    logic              rd_en;
    logic              ovf_clr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_err;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              thresh_irq;

    modport master (
        output rx_done, rx_data, rx_error, rd_en, ovf_clr,
        input  rd_data, rd_err, rd_valid, empty, full, count, overflow, thresh_irq
    );

    modport slave (
        input  rx_done, rx_data, rx_error, rd_en, ovf_clr,
        output rd_data, rd_err, rd_valid, empty, full, count, overflow, thresh_irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - circular receive FIFO tagging each byte with its framing-error flag
module uart_rx_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int THRESH = 8
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int CW = ADDR_W + 1;

    logic [WIDTH:0]      mem [DEPTH];

    logic                rx_done_q,  rx_done_d;
    logic                wr_pend_q,  wr_pend_d;
    logic [WIDTH-1:0]    hold_q,     hold_d;
    logic [ADDR_W-1:0]   wptr_q,     wptr_d;
    logic [ADDR_W-1:0]   rptr_q,     rptr_d;
    logic [CW-1:0]       count_q,    count_d;
    logic [WIDTH-1:0]    rd_data_q,  rd_data_d;
    logic                rd_err_q,   rd_err_d;
    logic                rd_valid_q, rd_valid_d;
    logic                ovf_q,      ovf_d;

    logic                empty, full, pop, wr, drop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
        pop   = bus.rd_en && !empty;
        // A pop frees a slot in the same cycle, so a full FIFO can still accept.
        wr    = wr_pend_q && (!full || pop);
        drop  = wr_pend_q && !wr;

        rx_done_d  = bus.rx_done;
        wr_pend_d  = 1'b0;
        hold_d     = hold_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_err_d   = rd_err_q;
        rd_valid_d = pop;
        ovf_d      = ovf_q;

        if (bus.rx_done && !rx_done_q) begin
            hold_d    = bus.rx_data;
            wr_pend_d = 1'b1;
        end
        if (wr) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d    = rptr_q + 1'b1;
            rd_data_d = mem[rptr_q][WIDTH-1:0];
            rd_err_d  = mem[rptr_q][WIDTH];
        end
        case ({wr, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_done_q  <= 1'b0;
            wr_pend_q  <= 1'b0;
            hold_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (rst) begin
            rx_done_q  <= 1'b0;
            wr_pend_q  <= 1'b0;
            hold_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rx_done_q  <= rx_done_d;
            wr_pend_q  <= wr_pend_d;
            hold_q     <= hold_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    // The error flag arrives one cycle after the byte, i.e. in the write cycle.
    always_ff @(posedge clk) begin
        if (wr && !rst) begin
            mem[wptr_q] <= {bus.rx_error, hold_q};
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.count      = count_q;
    assign bus.overflow   = ovf_q;
    assign bus.thresh_irq = (count_q >= CW'(THRESH));
endmodule
